w_expand: RTL



---
 rtl/w_expand_pkg.sv | 30 +++
 rtl/w_sched_next.sv | 15 +
 rtl/w_expand.sv | 76 +++++++
 3 files changed

// File: rtl/w_expand_pkg.sv
// Shared SHA-256 message-schedule constants, FSM encoding and sigma helpers.
// Imported by the W expander and its next-word combinational block.
package w_expand_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_ROUNDS = 64;
  localparam int WIN_WORDS  = 16;
  localparam int WARR_S     = WIN_WORDS * WORD_W;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Lower-case sigma functions of the message schedule.
  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/w_sched_next.sv
// Next schedule word from the sliding window: s1(w14) + w9 + s0(w1) + w0, mod 2^32.
// Purely combinational; no flow control.
module w_sched_next
  import w_expand_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_new
);

  assign w_new = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/w_expand.sv
// Expands a 16-word window into the 64-word SHA-256 schedule, one word per cycle.
// First word one cycle after the accepting en; hold freezes the schedule, en is ignored unless ready.
module w_expand
  import w_expand_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WARR_S-1:0] W_in,
  input  logic              hold,
  output logic              ready,
  output logic              w_valid,
  output logic [WORD_W-1:0] w_out,
  output logic [IDX_W-1:0]  w_idx,
  output logic              done
);

  state_t             state;
  state_t             state_nxt;
  logic [WORD_W-1:0]  win [WIN_WORDS];
  logic [IDX_W-1:0]   t;
  logic [WORD_W-1:0]  w_new;
  logic               load;
  logic               consume;
  logic               last_word;

  assign load      = (state == ST_IDLE) && en;
  assign consume   = (state == ST_RUN) && !hold;
  assign last_word = (t == IDX_W'(NUM_ROUNDS - 1));

  w_sched_next u_next (
    .w0    (win[0]),
    .w1    (win[1]),
    .w9    (win[9]),
    .w14   (win[14]),
    .w_new (w_new)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (!hold && last_word) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The word computed on the final consume is shifted in but never presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_WORDS; i++) win[i] <= '0;
      t <= '0;
    end else if (load) begin
      for (int i = 0; i < WIN_WORDS; i++)
        win[i] <= W_in[WARR_S-1-i*WORD_W -: WORD_W];
      t <= '0;
    end else if (consume) begin
      for (int i = 0; i < WIN_WORDS-1; i++) win[i] <= win[i+1];
      win[WIN_WORDS-1] <= w_new;
      t <= t + IDX_W'(1);
    end
  end

  assign ready   = (state == ST_IDLE);
  assign w_valid = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign w_out   = win[0];
  assign w_idx   = t;

endmodule
